// File: rtl/vx_mem_rr_arbiter.sv
// vx_mem_rr_arbiter: round-robin share of one memory port among NUM_REQS requesters (core_req_* in, mem_req_*/mem_rsp_* to memory, core_rsp_* routed back by tag index, pending_reads/busy status)
module vx_mem_rr_arbiter #(
  parameter int NUM_REQS      = 4,
  parameter int ADDR_WIDTH    = 26,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int MAX_PENDING   = 16,
  parameter int IDX_W         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_W,
  parameter int CNT_W         = $clog2(MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              core_req_valid,
  input  logic [NUM_REQS-1:0]              core_req_rw,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0] core_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   core_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] core_req_tag,
  output logic [NUM_REQS-1:0]              core_req_ready,
  output logic [NUM_REQS-1:0]              core_rsp_valid,
  output logic [DATA_WIDTH-1:0]            core_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          core_rsp_tag,
  input  logic [NUM_REQS-1:0]              core_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic [CNT_W-1:0]                 pending_reads,
  output logic                             busy
);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int BE_W   = DATA_WIDTH / 8;
  logic [IDX_WS-1:0]        r_ptr;
  logic                     r_valid;
  logic                     r_rw;
  logic [BE_W-1:0]          r_be;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [TAG_OUT_WIDTH-1:0] r_tag;
  logic [CNT_W-1:0]         r_pend;
  logic [NUM_REQS-1:0]      w_elig;
  logic                     w_found;
  logic [IDX_WS-1:0]        w_win;
  logic                     w_can_load;
  logic                     w_fire;
  logic                     w_rd_fire;
  logic [TAG_OUT_WIDTH-1:0] w_tag_out;
  logic [IDX_WS-1:0]        w_rsp_idx;
  logic                     w_rsp_ok;
  logic                     w_rsp_fire;
  assign w_elig     = core_req_valid & (core_req_rw | {NUM_REQS{r_pend < CNT_W'(MAX_PENDING)}});
  assign w_can_load = ~r_valid | mem_req_ready;
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!w_found && w_elig[(int'(r_ptr) + k) % NUM_REQS]) begin
        w_found = 1'b1;
        w_win   = IDX_WS'((int'(r_ptr) + k) % NUM_REQS);
      end
    end
  end
  assign w_fire         = w_found & w_can_load;
  assign w_rd_fire      = w_fire & ~core_req_rw[w_win];
  assign core_req_ready = w_fire ? (NUM_REQS'(1) << w_win) : '0;
  if (IDX_W > 0) begin : g_idx
    assign w_tag_out = {w_win, core_req_tag[int'(w_win)*TAG_IN_WIDTH +: TAG_IN_WIDTH]};
    assign w_rsp_idx = mem_rsp_tag[TAG_OUT_WIDTH-1 -: IDX_WS];
  end else begin : g_noidx
    assign w_tag_out = core_req_tag;
    assign w_rsp_idx = '0;
  end
  // indices beyond NUM_REQS only occur for non-power-of-2 counts; such responses are drained and dropped
  assign w_rsp_ok       = {1'b0, w_rsp_idx} < (IDX_WS + 1)'(NUM_REQS);
  assign core_rsp_valid = (mem_rsp_valid & w_rsp_ok) ? (NUM_REQS'(1) << w_rsp_idx) : '0;
  assign core_rsp_data  = mem_rsp_data;
  assign core_rsp_tag   = mem_rsp_tag[TAG_IN_WIDTH-1:0];
  assign mem_rsp_ready  = w_rsp_ok ? core_rsp_ready[w_rsp_idx] : 1'b1;
  assign w_rsp_fire     = mem_rsp_valid & mem_rsp_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_pend  <= '0;
    end else begin
      r_valid <= w_fire | (r_valid & ~mem_req_ready);
      if (w_fire) r_ptr <= (int'(w_win) == NUM_REQS - 1) ? '0 : w_win + 1'b1;
      r_pend <= (w_rd_fire & ~w_rsp_fire) ? r_pend + 1'b1 :
                (~w_rd_fire & w_rsp_fire & (r_pend != '0)) ? r_pend - 1'b1 : r_pend;
    end
  end
  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_rw   <= core_req_rw[w_win];
      r_be   <= core_req_byteen[int'(w_win)*BE_W +: BE_W];
      r_addr <= core_req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      r_data <= core_req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
      r_tag  <= w_tag_out;
    end
  end
  assign mem_req_valid  = r_valid;
  assign mem_req_rw     = r_rw;
  assign mem_req_byteen = r_be;
  assign mem_req_addr   = r_addr;
  assign mem_req_data   = r_data;
  assign mem_req_tag    = r_tag;
  assign pending_reads  = r_pend;
  assign busy           = r_valid | (r_pend != '0);
endmodule
